// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AW/W/B or AR/R transaction out,
// one response pulse back, with an optional per-command timeout against a hung slave.
module axil_cfg_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_err,
  // write address channel
  output logic [ADDR_W-1:0] m_axi_aw_addr,
  output logic              m_axi_aw_valid,
  input  logic              m_axi_aw_ready,
  // write data channel
  output logic [DATA_W-1:0] m_axi_w_data,
  output logic              m_axi_w_valid,
  input  logic              m_axi_w_ready,
  // write response channel
  input  logic [1:0]        m_axi_b_resp,
  input  logic              m_axi_b_valid,
  output logic              m_axi_b_ready,
  // read address channel
  output logic [ADDR_W-1:0] m_axi_ar_addr,
  output logic              m_axi_ar_valid,
  input  logic              m_axi_ar_ready,
  // read data channel
  input  logic [DATA_W-1:0] m_axi_r_data,
  input  logic [1:0]        m_axi_r_resp,
  input  logic              m_axi_r_valid,
  output logic              m_axi_r_ready,
  // FSM state for observation
  output logic [2:0]        dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where valid && ready
  // are both high; valid, once raised, holds with stable payload until that edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WAIT_B = 3'd2,
    S_RD     = 3'd3,
    S_WAIT_R = 3'd4
  } state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                done;
  logic [1:0]          done_resp;
  logic [DATA_W-1:0]   done_data;
  logic                timeout_hit;

  assign cmd_ready      = (state_q == S_IDLE);
  assign m_axi_aw_addr  = addr_q;
  assign m_axi_ar_addr  = addr_q;
  assign m_axi_w_data   = wdata_q;
  assign m_axi_aw_valid = (state_q == S_WR) && aw_pend_q;
  assign m_axi_w_valid  = (state_q == S_WR) && w_pend_q;
  assign m_axi_b_ready  = (state_q == S_WR) || (state_q == S_WAIT_B);
  assign m_axi_ar_valid = (state_q == S_RD);
  assign m_axi_r_ready  = (state_q == S_RD) || (state_q == S_WAIT_R);
  assign dbg_state      = state_q;

  always_comb begin
    state_d     = state_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    done        = 1'b0;
    done_resp   = 2'b00;
    done_data   = '0;
    accept      = cmd_valid && (state_q == S_IDLE);
    // cnt_q counts non-IDLE cycles already elapsed, so this fires on the TIMEOUT-th one
    timeout_hit = (TIMEOUT != 0) && (state_q != S_IDLE) && (cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = cmd_write ? S_WR : S_RD;
          aw_pend_d = cmd_write;
          w_pend_d  = cmd_write;
        end
      end
      S_WR: begin
        if (m_axi_aw_ready) aw_pend_d = 1'b0;
        if (m_axi_w_ready)  w_pend_d  = 1'b0;
        // a B beat arriving on the cycle both handshakes finish must not be lost
        if (!aw_pend_d && !w_pend_d) begin
          if (m_axi_b_valid) begin
            done      = 1'b1;
            done_resp = m_axi_b_resp;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT_B;
          end
        end
      end
      S_WAIT_B: begin
        if (m_axi_b_valid) begin
          done      = 1'b1;
          done_resp = m_axi_b_resp;
          state_d   = S_IDLE;
        end
      end
      S_RD: begin
        if (m_axi_ar_ready) state_d = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (m_axi_r_valid) begin
          done      = 1'b1;
          done_resp = m_axi_r_resp;
          done_data = m_axi_r_data;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a completion on the timeout cycle still reports as a normal response
    if (timeout_hit && !done) begin
      state_d   = S_IDLE;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rsp_valid <= done || timeout_hit;
      rsp_err   <= timeout_hit && !done;

      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        cnt_q   <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (done) begin
        rsp_resp  <= done_resp;
        rsp_rdata <= done_data;
      end else if (timeout_hit) begin
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master: a small behavioural config slave plus a linear
// sequence of cycle-exact steps, with TIMEOUT set to 8 for the hung-slave case.
module tb_axil_cfg_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int pulses;

  // slave behaviour knobs
  logic        slv_no_b;
  logic [31:0] mem [0:15];
  logic        aw_got, w_got, aw_hs, w_hs;
  logic [31:0] wa_q, wd_q, cur_addr, cur_data;

  axil_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .m_axi_aw_addr(aw_addr), .m_axi_aw_valid(aw_valid), .m_axi_aw_ready(aw_ready),
    .m_axi_w_data(w_data), .m_axi_w_valid(w_valid), .m_axi_w_ready(w_ready),
    .m_axi_b_resp(b_resp), .m_axi_b_valid(b_valid), .m_axi_b_ready(b_ready),
    .m_axi_ar_addr(ar_addr), .m_axi_ar_valid(ar_valid), .m_axi_ar_ready(ar_ready),
    .m_axi_r_data(r_data), .m_axi_r_resp(r_resp), .m_axi_r_valid(r_valid), .m_axi_r_ready(r_ready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural slave: B/R one cycle after the completing handshake, single-cycle pulses
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      b_valid <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 32'h0;
      wa_q    <= 32'h0;
      wd_q    <= 32'h0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[3]  <= 32'hCAFEBABE;
    end else begin
      aw_hs    = aw_valid && aw_ready;
      w_hs     = w_valid && w_ready;
      cur_addr = aw_hs ? aw_addr : wa_q;
      cur_data = w_hs ? w_data : wd_q;
      b_valid  <= 1'b0;
      r_valid  <= 1'b0;
      if (aw_hs) wa_q <= aw_addr;
      if (w_hs)  wd_q <= w_data;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[cur_addr[5:2]] <= cur_data;
        b_valid <= !slv_no_b;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (ar_valid && ar_ready) begin
        r_valid <= 1'b1;
        r_data  <= mem[ar_addr[5:2]];
      end
    end
  end

  // driver tasks: each step lands 1 time unit after a rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    aw_ready  = 1'b1;
    w_ready   = 1'b1;
    ar_ready  = 1'b1;
    b_resp    = 2'b00;
    r_resp    = 2'b00;
    slv_no_b  = 1'b0;
    repeat (3) cyc();

    // reset values
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {28'd0, aw_valid, w_valid, ar_valid, rsp_valid}, 32'd0);
    chk("rst_readies", {29'd0, b_ready, r_ready, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_resp", 32'(rsp_resp), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: write 0x4 <= 0x20, zero-wait slave
    send(1'b1, 32'h4, 32'h20);
    chk("t1_T_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    chk("t1_T1_awv", 32'(aw_valid), 32'd1);
    chk("t1_T1_wv", 32'(w_valid), 32'd1);
    chk("t1_T1_addr", aw_addr, 32'h4);
    chk("t1_T1_data", w_data, 32'h20);
    chk("t1_T1_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("t1_T2_valids", {30'd0, aw_valid, w_valid}, 32'd0);
    chk("t1_T2_bready", 32'(b_ready), 32'd1);
    chk("t1_T2_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t1_T3_rsp", 32'(rsp_valid), 32'd1);
    chk("t1_T3_resp", 32'(rsp_resp), 32'd0);
    chk("t1_T3_err", 32'(rsp_err), 32'd0);
    chk("t1_T3_ready", 32'(cmd_ready), 32'd1);
    cyc();
    chk("t1_T4_rsp", 32'(rsp_valid), 32'd0);

    // 2: read 0xC
    send(1'b0, 32'hC, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    chk("t2_T1_arv", 32'(ar_valid), 32'd1);
    chk("t2_T1_araddr", ar_addr, 32'hC);
    chk("t2_T1_awv", 32'(aw_valid), 32'd0);
    cyc();
    chk("t2_T2_arv", 32'(ar_valid), 32'd0);
    chk("t2_T2_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t2_T3_rsp", 32'(rsp_valid), 32'd1);
    chk("t2_T3_rdata", rsp_rdata, 32'hCAFEBABE);
    chk("t2_T3_resp", 32'(rsp_resp), 32'd0);
    cyc();

    // 3: write 0x8 <= 0x55, w_ready low until T+4, slave answers EXOKAY
    w_ready = 1'b0;
    b_resp  = 2'b01;
    pulses  = 0;
    send(1'b1, 32'h8, 32'h55);
    cyc();
    cmd_valid = 1'b0;
    chk("t3_T1_both", {30'd0, aw_valid, w_valid}, 32'd3);
    cyc();
    chk("t3_T2_awv", 32'(aw_valid), 32'd0);
    chk("t3_T2_wv", 32'(w_valid), 32'd1);
    cyc();
    chk("t3_T3_wv", 32'(w_valid), 32'd1);
    cyc();
    chk("t3_T4_wv", 32'(w_valid), 32'd1);
    w_ready = 1'b1;
    cyc();
    chk("t3_T5_wv", 32'(w_valid), 32'd0);
    chk("t3_T5_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t3_T6_rsp", 32'(rsp_valid), 32'd1);
    chk("t3_T6_resp", 32'(rsp_resp), 32'd1);
    chk("t3_T6_rdata", rsp_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rsp_valid) pulses++;
    end
    chk("t3_single_pulse", 32'(pulses), 32'd0);
    b_resp = 2'b00;

    // read back 0x4, leaves rsp_rdata non-zero before the timeout case
    send(1'b0, 32'h4, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    chk("rb_rsp", 32'(rsp_valid), 32'd1);
    chk("rb_rdata", rsp_rdata, 32'h20);
    cyc();

    // 4: slave never sends B, TIMEOUT=8
    slv_no_b = 1'b1;
    send(1'b1, 32'h10, 32'h77);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (rsp_valid) pulses++;
      cyc();
    end
    chk("t4_no_early_rsp", 32'(pulses), 32'd0);
    chk("t4_T8_state", 32'(dbg_state), 32'd2);
    chk("t4_T8_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    chk("t4_T9_rsp", 32'(rsp_valid), 32'd1);
    chk("t4_T9_err", 32'(rsp_err), 32'd1);
    chk("t4_T9_resp", 32'(rsp_resp), 32'd2);
    chk("t4_T9_rdata", rsp_rdata, 32'd0);
    chk("t4_T9_lines", {28'd0, aw_valid, w_valid, b_ready, r_ready}, 32'd0);
    chk("t4_T9_ready", 32'(cmd_ready), 32'd1);
    cyc();
    chk("t4_T10_pulse", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("t4_T10_hold", 32'(rsp_resp), 32'd2);
    slv_no_b = 1'b0;

    // 5: back-to-back write 0x0 <= 1 then read 0x0
    send(1'b1, 32'h0, 32'h1);
    cyc();
    send(1'b0, 32'h0, 32'h0);
    chk("t5_T1_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("t5_T2_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("t5_T3_rsp", 32'(rsp_valid), 32'd1);
    chk("t5_T3_resp", 32'(rsp_resp), 32'd0);
    chk("t5_T3_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    chk("t5_T4_arv", 32'(ar_valid), 32'd1);
    chk("t5_T4_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    cyc();
    chk("t5_T6_rsp", 32'(rsp_valid), 32'd1);
    chk("t5_T6_rdata", rsp_rdata, 32'h1);
    cyc();

    // 6: reset for one cycle while waiting for B
    slv_no_b = 1'b1;
    send(1'b1, 32'h8, 32'h99);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("t6_pre_state", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_state", 32'(dbg_state), 32'd0);
    chk("t6_valids", {28'd0, aw_valid, w_valid, ar_valid, rsp_valid}, 32'd0);
    chk("t6_readies", {29'd0, b_ready, r_ready, rsp_err}, 32'd0);
    chk("t6_rdata", rsp_rdata, 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (rsp_valid) pulses++;
    end
    chk("t6_no_rsp", 32'(pulses), 32'd0);
    slv_no_b = 1'b0;
    send(1'b0, 32'hC, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_new_rsp", 32'(rsp_valid), 32'd1);
    chk("t6_new_rdata", rsp_rdata, 32'hCAFEBABE);
    cyc();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
